alu_control_md: RTL and testbench
=================================

// Module: alu_control_md
// PURPOSE
//  Next-generation ALU control for the RV32 core. Decodes {func7_5, func7_0, func3} and alu_op into the
//  4-bit ALU control code, as the existing single-cycle decoder does, and adds the M-extension ops
//  MUL, MULH, DIV, DIVU, REM and REMU. It contains the multi-cycle multiply/divide sequencer and datapath.
//  Sits in EX: alu_control drives the ALU; md_stall freezes IF/ID/EX while a mul/div runs.
// PARAMETERS
//  DATA_W    32  operand/result width; must be even and >= 8
//  MUL_STEP  1   multiplier bits retired per cycle; allowed values 1, 2, 4; must divide DATA_W
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  arst        in   1       asynchronous reset, active-high
//  in_valid    in   1       EX holds a valid instruction this cycle
//  flush       in   1       synchronous kill of any mul/div in flight (branch/exception)
//  func7_5     in   1       instr[30]
//  func7_0     in   1       instr[25]
//  func3       in   3       instr[14:12]
//  alu_op      in   2       00 add, 01 sub, 10 R-type, 11 reserved
//  operand_a   in   DATA_W  rs1 value; held stable by the pipeline while md_stall=1
//  operand_b   in   DATA_W  rs2 value; held stable by the pipeline while md_stall=1
//  alu_control out  4       ALU control code (combinational)
//  md_stall    out  1       pipeline hold request (combinational)
//  md_valid    out  1       md_result valid this cycle (registered)
//  md_result   out  DATA_W  mul/div/rem result (registered)
// BEHAVIOUR
//  Codes: AND 0, OR 1, ADD 2, SLL 3, SRL 4, SUB 6, SLT 7, MUL 8, MULH 9, DIV 10, DIVU 11, REM 12, REMU 13.
//  alu_op 00->ADD, 01->SUB, 11->0. alu_op 10, func7_5=0, func7_0=0: func3 000 ADD, 111 AND, 110 OR,
//   010 SLT, 001 SLL, 101 SRL. func7_5=1, func7_0=0, func3=000: SUB. All other fields -> 0.
//  md_op = in_valid & alu_op==10 & func7_5==0 & func7_0==1; func3 000 MUL, 001 MULH, 100 DIV,
//   101 DIVU, 110 REM, 111 REMU. The md_op is qualified by in_valid and has no further decode gating.
//   Other func3 values produce code 0 and never start the sequencer.
//   alu_control shows the M code for the whole op.
//  FSM states IDLE, MUL, DIV, DONE. Reset state is IDLE; md_valid=0, md_result=0, counter=0.
//   IDLE: if md_op & ~flush, capture operands and signs, clear the accumulator and go to MUL or DIV.
//   MUL: shift-add on magnitudes, MUL_STEP bits/cycle, for DATA_W/MUL_STEP cycles, then go to DONE.
//   DIV: restoring division on magnitudes, 1 bit/cycle, for DATA_W cycles, then go to DONE.
//   DONE: one cycle with md_valid=1 and md_result held; then go to IDLE.
//    In DONE, in_valid is ignored, so the retiring op is never restarted.
//  md_stall = md_op & (state != DONE) & ~flush.
//   Stall lasts N+1 cycles: N=DATA_W/MUL_STEP for mul, N=DATA_W for div.
//   md_valid is high in the first cycle after stall drops. md_result holds until the next DONE.
//  Sign rules:
//   MUL: low DATA_W bits of the product; the same result for any sign.
//   MULH: high DATA_W bits of the signed x signed 2*DATA_W-bit product.
//    The magnitude product is negated iff sign(a) ^ sign(b).
//   DIV/REM: quotient is negated iff signs differ; remainder takes the sign of the dividend.
//  Boundary cases:
//   divide by zero: quotient = all ones, remainder = operand_a. Full latency still applies.
//   signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//   flush in any state: go to IDLE next edge, md_valid stays 0, and md_result is not updated.
//   arst mid-op: immediate return to IDLE with all registers cleared. md_stall drops combinationally.
//    If md_op is still present after reset, the op restarts from IDLE.
// TESTING
//  (DATA_W=32, MUL_STEP=1 unless stated)
//  1. Decode sweep over all alu_op/func combos, including reserved alu_op=11 and unknown funcs,
//     checked against the code table, with md_stall=0 for every non-M op.
//  2. MUL 7*6: stall 33 cycles, then md_valid=1 with 42. MULH 0x80000000*0x80000000 -> 0x40000000.
//     MULH -1*1 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     Each stalls 33 cycles.
//  4. Divide by 0: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000,
//     REM -> 0.
//  5. Flush at cycle 10 of a DIV: next cycle IDLE, no md_valid, md_result keeps its prior value.
//     arst at cycle 5 of a MUL clears all outputs asynchronously.
//  6. Back-to-back MUL then DIV: the second op starts in the cycle after DONE and both results
//     are correct. Rerun with MUL_STEP=4: MUL 7*6 stalls 9 cycles.

Source files
------------

// File: rtl/alu_control_md.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_md
// Brief    : RV32 ALU control decode plus multi-cycle M-extension mul/div unit
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_md #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              func7_5,
    input  logic              func7_0,
    input  logic [2:0]        func3,
    input  logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [3:0]        alu_control,
    output logic              md_stall,
    output logic              md_valid,
    output logic [DATA_W-1:0] md_result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_MUL_LAST = CNT_W'(DATA_W / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(DATA_W - 1);

    localparam logic [3:0] c_AND  = 4'd0;
    localparam logic [3:0] c_OR   = 4'd1;
    localparam logic [3:0] c_ADD  = 4'd2;
    localparam logic [3:0] c_SLL  = 4'd3;
    localparam logic [3:0] c_SRL  = 4'd4;
    localparam logic [3:0] c_SUB  = 4'd6;
    localparam logic [3:0] c_SLT  = 4'd7;
    localparam logic [3:0] c_MUL  = 4'd8;
    localparam logic [3:0] c_MULH = 4'd9;
    localparam logic [3:0] c_DIV  = 4'd10;
    localparam logic [3:0] c_DIVU = 4'd11;
    localparam logic [3:0] c_REM  = 4'd12;
    localparam logic [3:0] c_REMU = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplr_q, mplr_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                md_valid_q, md_valid_d;
    logic [DATA_W-1:0]   md_result_q, md_result_d;

    logic                w_is_m;
    logic                w_md_op;
    logic                w_sgn;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [2*DATA_W-1:0] w_pp;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_trial;
    logic [DATA_W-1:0]   w_quo_fin;
    logic [DATA_W-1:0]   w_rem_fin;

    always_comb begin
        alu_control = c_AND;
        w_is_m      = 1'b0;
        case (alu_op)
            2'b00: alu_control = c_ADD;
            2'b01: alu_control = c_SUB;
            2'b10: begin
                if (!func7_5 && !func7_0) begin
                    case (func3)
                        3'b000:  alu_control = c_ADD;
                        3'b111:  alu_control = c_AND;
                        3'b110:  alu_control = c_OR;
                        3'b010:  alu_control = c_SLT;
                        3'b001:  alu_control = c_SLL;
                        3'b101:  alu_control = c_SRL;
                        default: alu_control = c_AND;
                    endcase
                end else if (func7_5 && !func7_0 && func3 == 3'b000) begin
                    alu_control = c_SUB;
                end else if (!func7_5 && func7_0) begin
                    w_is_m = 1'b1;
                    case (func3)
                        3'b000:  alu_control = c_MUL;
                        3'b001:  alu_control = c_MULH;
                        3'b100:  alu_control = c_DIV;
                        3'b101:  alu_control = c_DIVU;
                        3'b110:  alu_control = c_REM;
                        3'b111:  alu_control = c_REMU;
                        default: w_is_m = 1'b0;
                    endcase
                end
            end
            default: alu_control = c_AND;
        endcase
    end

    assign w_md_op  = in_valid & w_is_m;
    // Gated by arst so the hold request releases the instant reset asserts.
    assign md_stall = w_md_op & (state_q != S_DONE) & ~flush & ~arst;

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplr_q[i]) begin
                w_pp = w_pp + (mcand_q << i);
            end
        end
    end

    assign w_div_shift = {rem_q, quo_q[DATA_W-1]};
    assign w_div_trial = w_div_shift - {1'b0, dvsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        md_valid_d  = 1'b0;
        md_result_d = md_result_q;
        w_sgn       = ~func3[2] | ~func3[0];
        w_mag_a     = operand_a;
        w_mag_b     = operand_b;
        w_prod      = '0;
        w_quo_fin   = '0;
        w_rem_fin   = '0;

        case (state_q)
            S_IDLE: begin
                if (w_md_op && !flush) begin
                    op_d    = func3[1:0];
                    sa_d    = w_sgn & operand_a[DATA_W-1];
                    sb_d    = w_sgn & operand_b[DATA_W-1];
                    w_mag_a = sa_d ? -operand_a : operand_a;
                    w_mag_b = sb_d ? -operand_b : operand_b;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{DATA_W{1'b0}}, w_mag_a};
                    mplr_d  = w_mag_b;
                    rem_d   = '0;
                    quo_d   = w_mag_a;
                    dvsr_d  = w_mag_b;
                    state_d = func3[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                acc_d   = acc_q + w_pp;
                mcand_d = mcand_q << MUL_STEP;
                mplr_d  = mplr_q >> MUL_STEP;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == c_MUL_LAST) begin
                    w_prod      = (sa_q ^ sb_q) ? -acc_d : acc_d;
                    md_result_d = op_q[0] ? w_prod[2*DATA_W-1:DATA_W] : w_prod[DATA_W-1:0];
                    md_valid_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = w_div_trial[DATA_W] ? w_div_shift[DATA_W-1:0] : w_div_trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], ~w_div_trial[DATA_W]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == c_DIV_LAST) begin
                    // Zero divisor forces all-ones; the remainder naturally equals the dividend.
                    w_quo_fin   = (dvsr_q == '0) ? '1 : ((sa_q ^ sb_q) ? -quo_d : quo_d);
                    w_rem_fin   = sa_q ? -rem_d : rem_d;
                    md_result_d = op_q[1] ? w_rem_fin : w_quo_fin;
                    md_valid_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            md_valid_d  = 1'b0;
            md_result_d = md_result_q;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            md_valid_q  <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            md_valid_q  <= md_valid_d;
            md_result_q <= md_result_d;
        end
    end

    assign md_valid  = md_valid_q;
    assign md_result = md_result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_md
// Brief    : Directed self-checking bench for alu_control_md (MUL_STEP 1 and 4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_md;

    logic        clk;
    logic        arst;
    logic        in_valid;
    logic        in_valid4;
    logic        flush;
    logic        func7_5;
    logic        func7_0;
    logic [2:0]  func3;
    logic [1:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic        md_stall;
    logic        md_valid;
    logic [31:0] md_result;
    logic [3:0]  alu_control4;
    logic        md_stall4;
    logic        md_valid4;
    logic [31:0] md_result4;

    int n_vec  = 0;
    int n_fail = 0;

    alu_control_md #(.DATA_W(32), .MUL_STEP(1)) u_dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .flush      (flush),
        .func7_5    (func7_5),
        .func7_0    (func7_0),
        .func3      (func3),
        .alu_op     (alu_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_control(alu_control),
        .md_stall   (md_stall),
        .md_valid   (md_valid),
        .md_result  (md_result)
    );

    alu_control_md #(.DATA_W(32), .MUL_STEP(4)) u_dut4 (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid4),
        .flush      (flush),
        .func7_5    (func7_5),
        .func7_0    (func7_0),
        .func3      (func3),
        .alu_op     (alu_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_control(alu_control4),
        .md_stall   (md_stall4),
        .md_valid   (md_valid4),
        .md_result  (md_result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_code(input logic [1:0] op, input logic f75,
                                            input logic f70, input logic [2:0] f3);
        logic [3:0] c;
        c = 4'd0;
        if (op == 2'b00) c = 4'd2;
        else if (op == 2'b01) c = 4'd6;
        else if (op == 2'b10) begin
            if (!f75 && !f70) begin
                case (f3)
                    3'b000:  c = 4'd2;
                    3'b110:  c = 4'd1;
                    3'b010:  c = 4'd7;
                    3'b001:  c = 4'd3;
                    3'b101:  c = 4'd4;
                    default: c = 4'd0;
                endcase
            end else if (f75 && !f70 && f3 == 3'b000) c = 4'd6;
            else if (!f75 && f70) begin
                case (f3)
                    3'b000:  c = 4'd8;
                    3'b001:  c = 4'd9;
                    3'b100:  c = 4'd10;
                    3'b101:  c = 4'd11;
                    3'b110:  c = 4'd12;
                    3'b111:  c = 4'd13;
                    default: c = 4'd0;
                endcase
            end
        end
        return c;
    endfunction

    task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        alu_op    = 2'b10;
        func7_5   = 1'b0;
        func7_0   = 1'b1;
        func3     = f3;
        operand_a = a;
        operand_b = b;
    endtask

    // Inputs were just applied at a falling edge; count stall cycles until release.
    task automatic measure(input string tag, input bit use4, input logic [31:0] exp_res,
                           input int exp_stall);
        int n;
        n = 0;
        #1;
        while ((use4 ? md_stall4 : md_stall) && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_valid"}, {31'd0, (use4 ? md_valid4 : md_valid)}, 32'd1);
        check({tag, "_result"}, (use4 ? md_result4 : md_result), exp_res);
    endtask

    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        @(negedge clk);
        set_op(f3, a, b);
        in_valid = 1'b1;
        measure(tag, 1'b0, exp_res, exp_stall);
    endtask

    initial begin
        logic [3:0] e;
        arst      = 1'b1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        flush     = 1'b0;
        func7_5   = 1'b0;
        func7_0   = 1'b0;
        func3     = 3'b000;
        alu_op    = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, md_valid}, 32'd0);
        check("rst_result", md_result, 32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // Decode sweep; M ops are presented without in_valid so nothing starts.
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 4; f++) begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    alu_op   = op[1:0];
                    func7_5  = f[1];
                    func7_0  = f[0];
                    func3    = k[2:0];
                    e        = exp_code(op[1:0], f[1], f[0], k[2:0]);
                    in_valid = (e < 4'd8);
                    #1;
                    check("dec_code", {28'd0, alu_control}, {28'd0, e});
                    check("dec_stall", {31'd0, md_stall}, 32'd0);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;

        run_md("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 33);
        run_md("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
        run_md("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_md("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_md("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_md("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_md("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_md("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_md("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        run_md("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 33);
        run_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_md("b2b_mul", 3'b000, 32'd123, 32'd456, 32'd56088, 33);
        run_md("b2b_div", 3'b100, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 33);

        // Flush in cycle 10 of a DIV: result keeps 0xFFFFFEB3 from the previous op.
        @(negedge clk);
        set_op(3'b101, 32'd100, 32'd7);
        in_valid = 1'b1;
        #1;
        check("b2b_held_valid", {31'd0, md_valid}, 32'd0);
        repeat (10) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("flush_stall", {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_valid", {31'd0, md_valid}, 32'd0);
        check("flush_result", md_result, 32'hFFFF_FEB3);
        @(negedge clk);
        #1;
        check("flush_valid2", {31'd0, md_valid}, 32'd0);
        run_md("post_flush", 3'b000, 32'd7, 32'd6, 32'd42, 33);

        // Asynchronous reset in cycle 5 of a MUL, then restart once released.
        @(negedge clk);
        set_op(3'b000, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_stall", {31'd0, md_stall}, 32'd0);
        check("arst_valid", {31'd0, md_valid}, 32'd0);
        check("arst_result", md_result, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        measure("arst_restart", 1'b0, 32'd15, 33);
        @(negedge clk);
        in_valid = 1'b0;

        @(negedge clk);
        set_op(3'b000, 32'd7, 32'd6);
        in_valid4 = 1'b1;
        measure("mul4_7x6", 1'b1, 32'd42, 9);
        @(negedge clk);
        set_op(3'b000, 32'hFFFF_FFFD, 32'd5);
        measure("mul4_neg", 1'b1, 32'hFFFF_FFF1, 9);
        @(negedge clk);
        in_valid4 = 1'b0;
        #1;
        check("mul4_idle_valid", {31'd0, md_valid4}, 32'd0);
        check("mul4_idle_result", md_result4, 32'hFFFF_FFF1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
